// File: rtl/nonce_sweep_scheduler_if.sv
// nonce_sweep_scheduler_if: host configuration, status and hash-core handshake bundle
// for the nonce sweep scheduler; slave is the scheduler, master is the host/core side.
interface nonce_sweep_scheduler_if #(
    parameter int LANES   = 16,
    parameter int NONCE_W = 32
);
    logic                  cfg_start;
    logic                  cfg_abort;
    logic [NONCE_W-1:0]    cfg_first_nonce;
    logic [NONCE_W-1:0]    cfg_last_nonce;
    logic [31:0]           cfg_target;
    logic                  core_start;
    logic [NONCE_W-1:0]    core_base_nonce;
    logic                  core_done;
    logic [LANES*32-1:0]   core_h0;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic                  exhausted;
    logic                  aborted;
    logic [NONCE_W-1:0]    found_nonce;
    logic [31:0]           batch_count;

    modport slave (
        input  cfg_start, cfg_abort, cfg_first_nonce, cfg_last_nonce, cfg_target, core_done, core_h0,
        output core_start, core_base_nonce, busy, done, found, exhausted, aborted, found_nonce, batch_count
    );

    modport master (
        output cfg_start, cfg_abort, cfg_first_nonce, cfg_last_nonce, cfg_target, core_done, core_h0,
        input  core_start, core_base_nonce, busy, done, found, exhausted, aborted, found_nonce, batch_count
    );
endinterface

// File: rtl/nonce_sweep_scheduler.sv
// nonce_sweep_scheduler: walks a multi-lane SHA-256d core across a nonce range in
// batches of LANES, stopping on the lowest in-range hit, range exhaustion or abort.
module nonce_sweep_scheduler #(
    parameter int LANES   = 16,
    parameter int NONCE_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nonce_sweep_scheduler_if.slave bus
);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FINISH} state_t;

    state_t              state, state_d;
    logic [NONCE_W-1:0]  base, last;
    logic [31:0]         target;
    logic                abort_q;
    logic [LANES*32-1:0] h0_q;
    logic                hit_any, last_batch;
    logic [IW-1:0]       hit_idx;

    // Descending scan so the lowest eligible hitting lane is the one that sticks.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (({1'b0, base} + (NONCE_W+1)'(i) <= {1'b0, last}) && (h0_q[32*i +: 32] < target)) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign last_batch = {1'b0, base} + (NONCE_W+1)'(LANES - 1) >= {1'b0, last};

    // An empty range is routed through CHECK: no lane is eligible and the
    // exhausted rule fires, which also gives done one cycle later than a direct jump.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.cfg_start) state_d = (bus.cfg_first_nonce > bus.cfg_last_nonce) ? CHECK : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.core_done) state_d = CHECK;
            CHECK:   state_d = (hit_any || abort_q || last_batch) ? FINISH : ISSUE;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    assign bus.core_base_nonce = base;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.core_start  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.found       <= 1'b0;
            bus.exhausted   <= 1'b0;
            bus.aborted     <= 1'b0;
            bus.found_nonce <= '0;
            bus.batch_count <= '0;
            base            <= '0;
            last            <= '0;
            target          <= '0;
            abort_q         <= 1'b0;
            h0_q            <= '0;
        end else begin
            bus.core_start <= state_d == ISSUE;
            bus.busy       <= state_d != IDLE;
            bus.done       <= state_d == FINISH;
            if (state == IDLE && bus.cfg_start) begin
                base            <= bus.cfg_first_nonce;
                last            <= bus.cfg_last_nonce;
                target          <= bus.cfg_target;
                bus.found       <= 1'b0;
                bus.exhausted   <= 1'b0;
                bus.aborted     <= 1'b0;
                bus.batch_count <= '0;
                abort_q         <= 1'b0;
            end
            if (state != IDLE && bus.cfg_abort) abort_q <= 1'b1;
            if (state == ISSUE) bus.batch_count <= bus.batch_count + 32'd1;
            if (state == WAIT && bus.core_done) h0_q <= bus.core_h0;
            if (state == CHECK) begin
                if (hit_any) begin
                    bus.found       <= 1'b1;
                    bus.found_nonce <= base + NONCE_W'(hit_idx);
                end else if (abort_q) begin
                    bus.aborted <= 1'b1;
                end else if (last_batch) begin
                    bus.exhausted <= 1'b1;
                end else begin
                    base <= base + NONCE_W'(LANES);
                end
            end
        end
    end
endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// tb_nonce_sweep_scheduler: directed and randomized sweeps against a batch-level
// reference model, with a behavioural hash-core responder of random latency.
module tb_nonce_sweep_scheduler;
    localparam int LANES = 16;
    localparam int NW    = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nonce_sweep_scheduler_if #(.LANES(LANES), .NONCE_W(NW)) b ();
    nonce_sweep_scheduler #(.LANES(LANES), .NONCE_W(NW)) dut (.clk(clk), .reset_n(reset_n), .bus(b));

    int          n_checks = 0;
    int          n_fail = 0;
    int          core_starts = 0;
    logic [31:0] hitq[$];
    bit          rnd_mode = 1'b0;
    logic [31:0] key = 32'd0;

    function automatic logic [31:0] h0_of(logic [31:0] n);
        foreach (hitq[i]) if (hitq[i] == n) return 32'h000F_FFFF;
        return rnd_mode ? ((n * 32'h9E37_79B1) ^ key) : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Batch-level reference: batch bi covers f+bi*LANES.., lanes beyond l are ignored.
    task automatic model(input logic [31:0] f, l, t, input int ab,
                         output bit ef, ea, ee, output logic [31:0] efn, output int ebc);
        longint base;
        ef = 0; ea = 0; ee = 0; efn = 0; ebc = 0;
        if (f > l) begin ee = 1; return; end
        for (int bi = 0; bi < (1 << 20); bi++) begin
            base = longint'({32'd0, f}) + longint'(bi) * LANES;
            ebc = bi + 1;
            for (int i = 0; i < LANES; i++)
                if (base + i <= longint'({32'd0, l}) && h0_of(32'(base + i)) < t) begin
                    ef = 1; efn = 32'(base + i); return;
                end
            if (bi >= ab) begin ea = 1; return; end
            if (base + LANES - 1 >= longint'({32'd0, l})) begin ee = 1; return; end
        end
    endtask

    initial begin
        logic [NW-1:0] cap;
        b.core_done = 1'b0;
        b.core_h0 = '0;
        forever begin
            @(posedge clk); #1;
            if (reset_n && b.core_start) begin
                core_starts++;
                cap = b.core_base_nonce;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                for (int i = 0; i < LANES; i++) b.core_h0[32*i +: 32] = h0_of(cap + 32'(i));
                b.core_done = 1'b1;
                chk("base_hold", b.core_base_nonce, cap);
                @(posedge clk); #1;
                b.core_done = 1'b0;
                b.core_h0 = '0;
            end
        end
    end

    task automatic sweep(input string tag, input logic [31:0] f, l, t,
                         input int abort_cyc, input int restart_cyc, output int cyc);
        bit ef, ea, ee;
        logic [31:0] efn;
        int ebc, s0;
        model(f, l, t, (abort_cyc != 0) ? 0 : (1 << 30), ef, ea, ee, efn, ebc);
        s0 = core_starts;
        b.cfg_first_nonce = f; b.cfg_last_nonce = l; b.cfg_target = t; b.cfg_start = 1'b1;
        @(posedge clk); #1;
        b.cfg_start = 1'b0;
        cyc = 1;
        chk({tag, ":busy1"}, b.busy, 1);
        chk({tag, ":core_start1"}, b.core_start, f <= l);
        while (!b.done && cyc < 3000) begin
            b.cfg_abort = (cyc == abort_cyc);
            if (cyc == restart_cyc) begin
                b.cfg_start = 1'b1; b.cfg_first_nonce = 32'd5; b.cfg_last_nonce = 32'd3; b.cfg_target = '1;
            end else b.cfg_start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        b.cfg_abort = 1'b0;
        b.cfg_start = 1'b0;
        chk({tag, ":done_seen"}, b.done, 1);
        chk({tag, ":busy_done"}, b.busy, 1);
        chk({tag, ":found"}, b.found, ef);
        chk({tag, ":aborted"}, b.aborted, ea);
        chk({tag, ":exhausted"}, b.exhausted, ee);
        chk({tag, ":batch_count"}, b.batch_count, ebc);
        if (ef) chk({tag, ":found_nonce"}, b.found_nonce, efn);
        chk({tag, ":core_starts"}, core_starts - s0, ebc);
        @(posedge clk); #1;
        chk({tag, ":done_pulse"}, b.done, 0);
        chk({tag, ":busy_after"}, b.busy, 0);
    endtask

    initial begin
        int cyc;
        logic [31:0] f, l, t;
        b.cfg_start = 0; b.cfg_abort = 0; b.cfg_first_nonce = 0; b.cfg_last_nonce = 0; b.cfg_target = 0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_start", b.core_start, 0);
        chk("rst_base", b.core_base_nonce, 0);
        chk("rst_busy", b.busy, 0);
        chk("rst_done", b.done, 0);
        chk("rst_found", b.found, 0);
        chk("rst_exhausted", b.exhausted, 0);
        chk("rst_aborted", b.aborted, 0);
        chk("rst_found_nonce", b.found_nonce, 0);
        chk("rst_batch_count", b.batch_count, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        hitq = '{32'h105};
        sweep("hit0", 32'h100, 32'h1FF, 32'h0010_0000, 0, 0, cyc);
        chk("hit0_nonce", b.found_nonce, 32'h105);
        chk("hit0_bc", b.batch_count, 1);

        hitq = '{32'h1023, 32'h1029};
        sweep("lowlane", 32'h1000, 32'h10FF, 32'h0010_0000, 0, 0, cyc);
        chk("lowlane_nonce", b.found_nonce, 32'h1023);
        chk("lowlane_bc", b.batch_count, 3);

        hitq = '{32'd21};
        sweep("partial", 32'd0, 32'd20, 32'h0010_0000, 0, 0, cyc);
        chk("partial_exh", b.exhausted, 1);
        chk("partial_bc", b.batch_count, 2);

        hitq.delete();
        sweep("top", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0010_0000, 0, 0, cyc);
        chk("top_bc", b.batch_count, 1);
        chk("top_base", b.core_base_nonce, 32'hFFFF_FFF0);
        sweep("top2", 32'hFFFF_FFE0, 32'hFFFF_FFFF, 32'h0010_0000, 0, 0, cyc);
        chk("top2_bc", b.batch_count, 2);
        chk("top2_base", b.core_base_nonce, 32'hFFFF_FFF0);

        sweep("abort", 32'd0, 32'hFFF, 32'h0010_0000, 2, 0, cyc);
        chk("abort_flag", b.aborted, 1);
        chk("abort_bc", b.batch_count, 1);
        hitq = '{32'd0};
        sweep("abort_hit", 32'd0, 32'hFFF, 32'h0010_0000, 2, 0, cyc);
        chk("abort_hit_found", b.found, 1);
        chk("abort_hit_ab", b.aborted, 0);

        hitq.delete();
        sweep("misuse", 32'd0, 32'd63, 32'h0010_0000, 0, 3, cyc);
        chk("misuse_bc", b.batch_count, 4);
        sweep("empty", 32'd10, 32'd9, 32'hFFFF_FFFF, 0, 0, cyc);
        chk("empty_cycle", cyc, 2);
        chk("empty_exh", b.exhausted, 1);

        b.cfg_first_nonce = 32'd0; b.cfg_last_nonce = 32'hFF; b.cfg_target = 32'd0; b.cfg_start = 1'b1;
        @(posedge clk); #1;
        b.cfg_start = 1'b0;
        @(posedge clk); #1;
        chk("rstw_busy_pre", b.busy, 1);
        chk("rstw_bc_pre", b.batch_count, 1);
        reset_n = 1'b0;
        #1;
        chk("rstw_busy", b.busy, 0);
        chk("rstw_done", b.done, 0);
        chk("rstw_core_start", b.core_start, 0);
        chk("rstw_bc", b.batch_count, 0);
        chk("rstw_exh", b.exhausted, 0);
        #2 reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rstw_idle", b.busy, 0);

        rnd_mode = 1'b1;
        for (int k = 0; k < 20; k++) begin
            key = $urandom;
            f = (k % 5 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 100)) : $urandom;
            l = f + 32'($urandom_range(0, 150));
            if (l < f) l = 32'hFFFF_FFFF;
            t = $urandom_range(0, 32'h0400_0000);
            sweep("rand", f, l, t, 0, 0, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
